// File: rtl/la_wb_counter_arbiter.sv
// ----------------------------------------------------------------------------
// la_wb_counter_arbiter
//   User-project counter block. A single 32-bit count register is shared by
//   three writers, highest priority first: a masked logic-analyzer load, a
//   Wishbone write to COUNT, and a free-running up/down engine. count[15:0]
//   is exported on the user IO pads so progress codes are visible off-chip.
//
// Ports
//   wb_clk_i, wb_rstn_i      clock, asynchronous active-low reset
//   wbs_*                    Wishbone slave (CTRL 0x0, COUNT 0x4, STATUS 0x8)
//   la_data_in, la_oenb      LA load value and per-bit ownership (0 = LA owns)
//   la_load_i                LA load request, acted on at its rising edge
//   io_out, io_oeb           count[15:0] and active-low output enables
//   irq_o                    sticky wrap flag gated by CTRL.irq_en
// ----------------------------------------------------------------------------
module la_wb_counter_arbiter #(
  parameter int unsigned WIDTH    = 32,
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter int unsigned IO_LSB   = 16,
  // Pad window driven by the count: mprj_io[IO_LSB+15:IO_LSB]
  localparam int unsigned IO_W    = (IO_LSB + 16) - IO_LSB
) (
  input  logic             wb_clk_i,
  input  logic             wb_rstn_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  input  logic [31:0]      la_data_in,
  input  logic [31:0]      la_oenb,
  input  logic             la_load_i,
  output logic [IO_W-1:0]  io_out,
  output logic [IO_W-1:0]  io_oeb,
  output logic             irq_o
);

  localparam logic [3:0] OFF_CTRL   = 4'h0;
  localparam logic [3:0] OFF_COUNT  = 4'h4;
  localparam logic [3:0] OFF_STATUS = 4'h8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_la_load_q;
  logic [WIDTH-1:0]   r_count;
  logic [3:0]         r_ctrl;      // {io_en, irq_en, down, en}
  logic               r_wrap;
  logic [7:0]         r_coll;
  logic [31:0]        r_wdat;
  logic [3:0]         r_wsel;
  logic [31:0]        r_rdata;
  logic               r_ack;
  logic [31:0]        r_dat_o;
  logic [IO_W-1:0]    r_io_out;
  logic [IO_W-1:0]    r_io_oeb;
  logic               r_irq;

  logic               w_ld_edge;
  logic               w_req;
  logic               w_wr_count;
  logic               w_cnt_wr;
  logic [31:0]        w_cnt_dat;
  logic [3:0]         w_cnt_sel;
  logic [WIDTH-1:0]   w_count_nxt;
  logic [3:0]         w_ctrl_nxt;
  logic               w_wrap_set;
  logic               w_wrap_clr;
  logic               w_wrap_nxt;
  logic [7:0]         w_coll_nxt;
  logic [31:0]        w_rd_mux;

  // Request accepted only in IDLE and not while the previous ack is still out
  assign w_req = (r_state == S_IDLE) && !r_ack && wbs_cyc_i && wbs_stb_i &&
                 (wbs_adr_i[31:4] == BASE_ADR[31:4]);
  assign w_wr_count = w_req && wbs_we_i && (wbs_adr_i[3:0] == OFF_COUNT);

  // Next-state of the arbitrated count, control and status registers
  always_comb begin
    w_ld_edge   = la_load_i & ~r_la_load_q;
    w_cnt_wr    = 1'b0;
    w_cnt_dat   = wbs_dat_i;
    w_cnt_sel   = wbs_sel_i;
    w_count_nxt = r_count;
    w_ctrl_nxt  = r_ctrl;
    w_wrap_set  = 1'b0;
    w_wrap_clr  = 1'b0;
    w_coll_nxt  = r_coll;
    w_rd_mux    = 32'd0;

    // COUNT write commits directly from IDLE, or from WAIT using latched data
    if (w_wr_count && !w_ld_edge) begin
      w_cnt_wr = 1'b1;
    end
    if ((r_state == S_WAIT) && wbs_cyc_i && !w_ld_edge) begin
      w_cnt_wr  = 1'b1;
      w_cnt_dat = r_wdat;
      w_cnt_sel = r_wsel;
    end

    if (w_wr_count && w_ld_edge && (r_coll != 8'hFF)) begin
      w_coll_nxt = r_coll + 8'd1;
    end

    if (w_req && wbs_we_i && (wbs_adr_i[3:0] == OFF_CTRL) && wbs_sel_i[0]) begin
      w_ctrl_nxt = wbs_dat_i[3:0];
    end
    if (w_req && wbs_we_i && (wbs_adr_i[3:0] == OFF_STATUS) && wbs_sel_i[0]) begin
      w_wrap_clr = wbs_dat_i[0];
    end

    // Priority: LA load edge, then WB write, then the increment engine
    if (w_ld_edge) begin
      w_count_nxt = WIDTH'((32'(r_count) & la_oenb) | (la_data_in & ~la_oenb));
    end else if (w_cnt_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (w_cnt_sel[b]) begin
          w_count_nxt[8*b +: 8] = w_cnt_dat[8*b +: 8];
        end
      end
    end else if (r_ctrl[0]) begin
      if (r_ctrl[1]) begin
        w_wrap_set  = ~|r_count;
        w_count_nxt = r_count - WIDTH'(1);
      end else begin
        w_wrap_set  = &r_count;
        w_count_nxt = r_count + WIDTH'(1);
      end
    end

    // A wrap in the same cycle as a clear wins
    w_wrap_nxt = (r_wrap & ~w_wrap_clr) | w_wrap_set;

    case (wbs_adr_i[3:0])
      OFF_CTRL:   w_rd_mux = {28'd0, r_ctrl};
      OFF_COUNT:  w_rd_mux = 32'(r_count);
      OFF_STATUS: w_rd_mux = {16'd0, r_coll, 7'd0, r_wrap};
      default:    w_rd_mux = 32'd0;
    endcase
  end

  // Register file, output registers and Wishbone FSM
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      r_state     <= S_IDLE;
      r_la_load_q <= 1'b0;
      r_count     <= '0;
      r_ctrl      <= 4'd0;
      r_wrap      <= 1'b0;
      r_coll      <= 8'd0;
      r_wdat      <= 32'd0;
      r_wsel      <= 4'd0;
      r_rdata     <= 32'd0;
      r_ack       <= 1'b0;
      r_dat_o     <= 32'd0;
      r_io_out    <= '0;
      r_io_oeb    <= '1;
      r_irq       <= 1'b0;
    end else begin
      r_la_load_q <= la_load_i;
      r_count     <= w_count_nxt;
      r_ctrl      <= w_ctrl_nxt;
      r_wrap      <= w_wrap_nxt;
      r_coll      <= w_coll_nxt;
      r_io_out    <= w_count_nxt[IO_W-1:0];
      r_io_oeb    <= w_ctrl_nxt[3] ? '0 : '1;
      r_irq       <= w_wrap_nxt & w_ctrl_nxt[2];
      r_ack       <= 1'b0;
      r_dat_o     <= 32'd0;

      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_rdata <= wbs_we_i ? 32'd0 : w_rd_mux;
            if (w_wr_count && w_ld_edge) begin
              r_wdat  <= wbs_dat_i;
              r_wsel  <= wbs_sel_i;
              r_state <= S_WAIT;
            end else begin
              r_state <= S_ACK;
            end
          end
        end
        S_WAIT: begin
          // Master abandoned the cycle: drop the write silently
          if (!wbs_cyc_i) begin
            r_state <= S_IDLE;
          end else if (!w_ld_edge) begin
            r_state <= S_ACK;
          end
        end
        S_ACK: begin
          r_ack   <= 1'b1;
          r_dat_o <= r_rdata;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat_o;
  assign io_out    = r_io_out;
  assign io_oeb    = r_io_oeb;
  assign irq_o     = r_irq;

endmodule
